// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the RAW hazard unit: operand reads, forward buses,
// issue/retire tracking and the merged results/stall returned to decode.
interface hazard_scoreboard_if #(
    parameter int NRD = 2,
    parameter int NST = 3,
    parameter int DW  = 32
);
    logic [NRD-1:0]    rd_en;
    logic [5*NRD-1:0]  rd_addr;
    logic [DW*NRD-1:0] rf_rdata;
    logic [NST-1:0]    st_we;
    logic [5*NST-1:0]  st_dest;
    logic [NST-1:0]    st_fwd_valid;
    logic [DW*NST-1:0] st_fwd_data;
    logic              issue_fire;
    logic              issue_we;
    logic [4:0]        issue_dest;
    logic              retire_we;
    logic [4:0]        retire_dest;
    logic              flush;
    logic [DW*NRD-1:0] rd_value;
    logic              stall;
    logic              issue_full;
    logic [31:0]       stall_cycles;

    modport master (
        output rd_en, rd_addr, rf_rdata, st_we, st_dest, st_fwd_valid, st_fwd_data,
        output issue_fire, issue_we, issue_dest, retire_we, retire_dest, flush,
        input  rd_value, stall, issue_full, stall_cycles
    );

    modport slave (
        input  rd_en, rd_addr, rf_rdata, st_we, st_dest, st_fwd_valid, st_fwd_data,
        input  issue_fire, issue_we, issue_dest, retire_we, retire_dest, flush,
        output rd_value, stall, issue_full, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Read-after-write hazard unit: youngest-stage forwarding per read port plus
// per-register pending-write counters for producers invisible on the forward buses.
module hazard_scoreboard #(
    parameter int NRD   = 2,
    parameter int NST   = 3,
    parameter int CNT_W = 2,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    hazard_scoreboard_if.slave   bus
);

    logic [CNT_W-1:0]  r_pend_cnt [1:31];
    logic [31:0]       r_stall_cycles;
    logic [31:0]       w_pend_nz;
    logic [31:0]       w_pend_full;
    logic [NRD-1:0]    w_port_stall;
    logic [DW*NRD-1:0] w_rd_value;
    logic              w_issue_full;
    logic              w_stall;
    logic              w_inc;
    logic              w_dec;

    always_comb begin
        w_pend_nz   = '0;
        w_pend_full = '0;
        for (int r = 1; r < 32; r++) begin
            w_pend_nz[r]   = |r_pend_cnt[r];
            w_pend_full[r] = &r_pend_cnt[r];
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [4:0]    w_a;
        logic          w_hit;
        logic          w_hit_rdy;
        logic [DW-1:0] w_hit_data;
        logic          w_pstall;
        logic [DW-1:0] w_val;

        assign w_a = bus.rd_addr[5*k +: 5];

        // Walk oldest to youngest so the youngest matching stage overrides.
        always_comb begin
            w_hit      = 1'b0;
            w_hit_rdy  = 1'b0;
            w_hit_data = '0;
            for (int j = NST - 1; j >= 0; j--) begin
                if (bus.st_we[j] && (bus.st_dest[5*j +: 5] == w_a)) begin
                    w_hit      = 1'b1;
                    w_hit_rdy  = bus.st_fwd_valid[j];
                    w_hit_data = bus.st_fwd_data[DW*j +: DW];
                end
            end
        end

        always_comb begin
            w_pstall = 1'b0;
            w_val    = bus.rf_rdata[DW*k +: DW];
            if (bus.rd_en[k] && (w_a != 5'd0)) begin
                if (w_hit) begin
                    if (w_hit_rdy) w_val = w_hit_data;
                    else           w_pstall = 1'b1;
                end else if (w_pend_nz[w_a]) begin
                    w_pstall = 1'b1;
                end
            end
        end

        assign w_port_stall[k]          = w_pstall;
        assign w_rd_value[DW*k +: DW]   = w_val;
    end

    assign w_issue_full = bus.issue_we && (bus.issue_dest != 5'd0) && w_pend_full[bus.issue_dest];
    assign w_stall      = (|w_port_stall) || w_issue_full;
    assign w_inc        = bus.issue_fire && bus.issue_we && (bus.issue_dest != 5'd0);
    assign w_dec        = bus.retire_we && (bus.retire_dest != 5'd0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cycles <= '0;
            for (int r = 1; r < 32; r++) r_pend_cnt[r] <= '0;
        end else begin
            if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
            // Flush clears tracking but leaves the performance counter alone.
            for (int r = 1; r < 32; r++) begin
                if (bus.flush) begin
                    r_pend_cnt[r] <= '0;
                end else if (w_inc && (bus.issue_dest == 5'(r)) && w_dec && (bus.retire_dest == 5'(r))) begin
                    r_pend_cnt[r] <= r_pend_cnt[r];
                end else if (w_inc && (bus.issue_dest == 5'(r)) && !w_pend_full[r]) begin
                    r_pend_cnt[r] <= r_pend_cnt[r] + 1'b1;
                end else if (w_dec && (bus.retire_dest == 5'(r)) && w_pend_nz[r]) begin
                    r_pend_cnt[r] <= r_pend_cnt[r] - 1'b1;
                end
            end
        end
    end

    assign bus.rd_value     = w_rd_value;
    assign bus.stall        = w_stall;
    assign bus.issue_full   = w_issue_full;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: expectations are queued as stimulus is
// driven and drained against the outputs on the falling edge.
module tb_hazard_scoreboard;

    localparam int NRD = 2;
    localparam int NST = 3;
    localparam int DW  = 32;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    exp_t        sb_q [$];
    exp_t        e;
    logic [31:0] act;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sc_exp  = 0;
    logic        exp_stall_now = 1'b0;

    hazard_scoreboard_if #(.NRD(NRD), .NST(NST), .DW(DW)) bus ();

    hazard_scoreboard #(.NRD(NRD), .NST(NST), .CNT_W(2), .DW(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       observe = bus.rd_value[31:0];
            1:       observe = bus.rd_value[63:32];
            2:       observe = {31'b0, bus.stall};
            3:       observe = {31'b0, bus.issue_full};
            default: observe = bus.stall_cycles;
        endcase
    endfunction

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        exp_t x;
        x.name = name;
        x.sel  = sel;
        x.exp  = exp;
        sb_q.push_back(x);
    endtask

    task automatic idle();
        bus.rd_en = '0; bus.rd_addr = '0; bus.rf_rdata = '0;
        bus.st_we = '0; bus.st_dest = '0; bus.st_fwd_valid = '0; bus.st_fwd_data = '0;
        bus.issue_fire = 1'b0; bus.issue_we = 1'b0; bus.issue_dest = '0;
        bus.retire_we = 1'b0; bus.retire_dest = '0; bus.flush = 1'b0;
        exp_stall_now = 1'b0;
    endtask

    task automatic adv();
        sc_exp = sc_exp + {31'b0, exp_stall_now};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        sc_exp = 0;
        bus.rd_en    = 2'b11;
        bus.rd_addr  = {5'd5, 5'd3};
        bus.rf_rdata = {32'h11, 32'h22};
        push("reset_v0", 0, 32'h22);
        push("reset_v1", 1, 32'h11);
        push("reset_stall", 2, 0);
        push("reset_full", 3, 0);
        push("reset_sc", 4, 0);
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); act = observe(e.sel); n_tests++;
            if (act !== e.exp) begin
                n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
            end
        end
        adv();
    endtask

    task automatic test_youngest_wins();
        logic [2:0]  we_t [5] = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b100};
        logic [2:0]  fv_t [5] = '{3'b111, 3'b110, 3'b101, 3'b110, 3'b100};
        logic [31:0] v_t  [5] = '{32'hA, 32'h0, 32'hA, 32'hB, 32'hC};
        logic        s_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 5; c++) begin
            idle();
            bus.rd_en        = 2'b01;
            bus.rd_addr      = {5'd0, 5'd7};
            bus.rf_rdata     = {32'h0, 32'h77};
            bus.st_we        = we_t[c];
            bus.st_dest      = {5'd7, 5'd7, 5'd7};
            bus.st_fwd_valid = fv_t[c];
            bus.st_fwd_data  = {32'hC, 32'hB, 32'hA};
            exp_stall_now    = s_t[c];
            push($sformatf("young_stall_%0d", c), 2, {31'b0, s_t[c]});
            if (!s_t[c]) push($sformatf("young_v0_%0d", c), 0, v_t[c]);
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front(); act = observe(e.sel); n_tests++;
                if (act !== e.exp) begin
                    n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
            adv();
        end
    endtask

    task automatic test_invisible_producer();
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0) begin
                bus.issue_fire = 1'b1; bus.issue_we = 1'b1; bus.issue_dest = 5'd9;
                push("inv_issue_stall", 2, 0);
            end else begin
                bus.rd_en    = 2'b10;
                bus.rd_addr  = {5'd9, 5'd0};
                bus.rf_rdata = {32'h99, 32'h0};
                if (c == 3) begin
                    bus.retire_we = 1'b1; bus.retire_dest = 5'd9;
                end
                exp_stall_now = (c != 4);
                push($sformatf("inv_stall_%0d", c), 2, {31'b0, exp_stall_now});
                if (c == 1 || c == 4) push($sformatf("inv_sc_%0d", c), 4, sc_exp);
                if (c == 4) push("inv_v1", 1, 32'h99);
            end
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front(); act = observe(e.sel); n_tests++;
                if (act !== e.exp) begin
                    n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
            adv();
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 6; c++) begin
            idle();
            bus.issue_we   = 1'b1;
            bus.issue_dest = 5'd4;
            bus.issue_fire = (c < 3) || (c == 4);
            if (c == 4) begin
                bus.retire_we = 1'b1; bus.retire_dest = 5'd4;
            end
            exp_stall_now = (c >= 3);
            push($sformatf("sat_full_%0d", c), 3, {31'b0, exp_stall_now});
            push($sformatf("sat_stall_%0d", c), 2, {31'b0, exp_stall_now});
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front(); act = observe(e.sel); n_tests++;
                if (act !== e.exp) begin
                    n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
            adv();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) begin
                bus.issue_fire = 1'b1; bus.issue_we = 1'b1; bus.issue_dest = 5'd9;
                push("flush_setup_stall", 2, 0);
            end else begin
                bus.rd_en    = 2'b11;
                bus.rd_addr  = {5'd9, 5'd4};
                bus.rf_rdata = {32'h99, 32'h44};
                bus.flush    = (c == 1);
                exp_stall_now = (c == 1);
                push($sformatf("flush_stall_%0d", c), 2, {31'b0, exp_stall_now});
                if (c == 2) begin
                    bus.issue_we = 1'b1; bus.issue_dest = 5'd4;
                    push("flush_v0", 0, 32'h44);
                    push("flush_v1", 1, 32'h99);
                    push("flush_full", 3, 0);
                    push("flush_sc_kept", 4, sc_exp);
                end
            end
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front(); act = observe(e.sel); n_tests++;
                if (act !== e.exp) begin
                    n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
            adv();
        end
    endtask

    task automatic test_r0_and_rd_en();
        for (int c = 0; c < 4; c++) begin
            idle();
            if (c == 0) begin
                bus.issue_fire = 1'b1; bus.issue_we = 1'b1; bus.issue_dest = 5'd0;
                push("r0_issue_full", 3, 0);
            end else if (c < 3) begin
                bus.issue_we     = 1'b1;
                bus.rd_en        = (c == 1) ? 2'b01 : 2'b11;
                bus.rd_addr      = {5'd6, 5'd0};
                bus.rf_rdata     = {32'h66, 32'h55};
                bus.st_we        = 3'b011;
                bus.st_dest      = {5'd0, 5'd6, 5'd0};
                bus.st_fwd_valid = 3'b001;
                bus.st_fwd_data  = {32'h0, 32'h0, 32'hFF};
                exp_stall_now    = (c == 2);
                push($sformatf("r0_v0_%0d", c), 0, 32'h55);
                push($sformatf("r0_stall_%0d", c), 2, {31'b0, exp_stall_now});
                push($sformatf("r0_full_%0d", c), 3, 0);
            end else begin
                push("final_sc", 4, sc_exp);
                push("final_stall", 2, 0);
            end
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front(); act = observe(e.sel); n_tests++;
                if (act !== e.exp) begin
                    n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
            adv();
        end
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        test_reset();
        test_youngest_wins();
        test_invisible_producer();
        test_saturation();
        test_flush();
        test_r0_and_rd_en();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised read-after-write hazard unit for the decode stage.
- Generalises the fixed 2-read-port, 3-stage stall/forward compare into N read ports and S forwarding stages.
- Adds a per-register pending-write counter that covers producers not visible on the forward buses, such as multi-cycle mul/div or outstanding loads.
- Decode instantiates it between the regfile read ports and the ds_to_es bus. It returns merged operand values and one stall flag.

Parameters:
- NRD, 2: number of operand read ports.
- NST, 3: number of forwarding stages. Index 0 is the youngest (es), NST-1 the oldest (ws).
- CNT_W, 2: width of each per-register pending counter. Maximum 2^CNT_W-1 outstanding writes per register.
- DW, 32: data width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- rd_en  in  NRD  read port k actually consumes a register. Callers clear it for sa, imm, jal and similar cases.
- rd_addr  in  5*NRD  packed read addresses; port k occupies [5k+4:5k].
- rf_rdata  in  DW*NRD  raw regfile data per port.
- st_we  in  NST  stage j holds a valid instruction that writes the GPR file.
- st_dest  in  5*NST  destination per stage.
- st_fwd_valid  in  NST  stage j result is available this cycle.
- st_fwd_data  in  DW*NST  result per stage.
- issue_fire  in  1  decode instruction handed to execute this cycle (ds_to_es_valid && es_allowin).
- issue_we  in  1  issued instruction writes a GPR.
- issue_dest  in  5  its destination.
- retire_we  in  1  writeback writes the regfile this cycle.
- retire_dest  in  5  writeback destination.
- flush  in  1  pipeline flush; discard all pending state.
- rd_value  out  DW*NRD  merged operand per port.
- stall  out  1  decode must hold.
- issue_full  out  1  issue_dest counter saturated; decode must not issue.
- stall_cycles  out  32  performance counter.

Behaviour:
- pend_cnt[r], r=1..31, is CNT_W bits and registered. Register 0 is never tracked; writes to r0 are ignored everywhere.
- Reset (resetn=0 at posedge): all pend_cnt=0, stall_cycles=0.
- Counter update per cycle, next-state priority:
  - flush → all 0.
  - Otherwise inc = issue_fire&&issue_we&&issue_dest!=0 and dec = retire_we&&retire_dest!=0.
  - Same register with inc and dec → unchanged.
  - Otherwise +1 on inc, -1 on dec.
  - Decrement of a 0 counter holds 0 (verification flags this as an assertion).
  - Increment of a saturated counter must not happen; issue_full guards it.
- issue_full = issue_we && issue_dest!=0 && pend_cnt[issue_dest]==all-ones. It is combinational and contributes to stall.
- Per-port hazard resolution, combinational, for port k with a=rd_addr[k]:
  - Skip entirely if !rd_en[k] or a==0. rd_value = rf_rdata, no stall.
  - Find the youngest j with st_we[j] && st_dest[j]==a.
  - Match found and st_fwd_valid[j]: rd_value = st_fwd_data[j], no stall from this port.
  - Match found and !st_fwd_valid[j]: stall. Older matches are never used.
  - No stage match and pend_cnt[a]!=0: stall (invisible producer).
  - No match and pend_cnt[a]==0: rd_value = rf_rdata[k].
- stall = OR of port stalls OR issue_full. Stall is independent of flush in the same cycle. Decode gates validity.
- stall_cycles increments by 1 each cycle stall=1. It wraps at 2^32 and is not cleared by flush.
- Latency: operand and stall outputs are combinational from inputs and current pend_cnt. Counter effects appear the next cycle.
- Retire same cycle as read of same register with no stage match: the counter still reads 1, so stall holds one extra cycle. This is required and deterministic.

Test Plan:
- Reset: hold resetn=0 2 cycles, then rd_addr={5,3}, rf_rdata={0x11,0x22} → rd_value={0x11,0x22}, stall=0, stall_cycles=0.
- Youngest-wins: st_we=3'b111, all dest=7, fwd_valid=3'b111, data={0xC,0xB,0xA} (j=2..0), port0 reads r7 → rd_value=0xA, stall=0. Set fwd_valid[0]=0 → stall=1 with data 0xB still present.
- Invisible producer: issue_fire, we, dest=9, then clear all st_we. Port1 reads r9 → stall=1 each cycle. Pulse retire_dest=9 → stall=1 that cycle, 0 the next; stall_cycles counts exactly.
- Saturation with CNT_W=2: issue to r4 three times without retire → issue_full=1, stall=1 on the 4th attempt, pend_cnt[4]=3. A same-cycle issue+retire to r4 keeps it at 3.
- Flush: pend_cnt[4]=3, pend_cnt[9]=1, assert flush → next cycle reads of r4/r9 give rf_rdata, stall=0.
- r0 and rd_en: issue to r0, then read r0 with a stage dest 0 forwarding 0xFF → rd_value=rf_rdata, stall=0. Port with rd_en=0 matching a non-ready stage → stall=0.
